// File: rtl/vram_wr_router.sv
// CPU-to-VRAM port-b write router.
// Decodes CPU/DMA writes against a set of base/size windows and rebases the
// address into the hit segment. Decoded writes go into a small FIFO, and the
// FIFO head drives the shared segment write bus. While freeze (sync_active) is
// high the FIFO does not drain, so VRAM contents stay stable during the sync
// copy. Writes that hit no window are dropped and counted.
module vram_wr_router #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned NUM_SEG    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [NUM_SEG*ADDR_W-1:0] SEG_BASE = {12'hD00, 12'hC00, 12'h400, 12'h000},
    parameter logic [NUM_SEG*ADDR_W-1:0] SEG_SIZE = {12'h020, 12'h100, 12'h800, 12'h400}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          freeze,
    output logic [ADDR_W-1:0]             seg_wraddr,
    output logic [DATA_W-1:0]             seg_wrdata,
    output logic [NUM_SEG-1:0]            seg_wren,
    output logic [15:0]                   drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          idle
);

    localparam int unsigned IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [ADDR_W-1:0] hit_off;
    logic [ADDR_W-1:0] diff;

    // Window match: an address below the base wraps to a large value and misses.
    // Scan from the top index down so the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        diff    = '0;
        for (int i = int'(NUM_SEG) - 1; i >= 0; i--) begin
            diff = wr_addr - SEG_BASE[i*ADDR_W +: ADDR_W];
            if (diff < SEG_SIZE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
                hit_off = diff;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  idx_mem  [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [15:0]       drop_q;

    logic full, empty;
    logic accept, push, drop, pop;

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);

    // Ready depends only on registered fill state, so a same-cycle pop never
    // frees a slot for a same-cycle push. It is held low while reset is asserted.
    assign wr_ready = rst_n & ~full;

    assign accept = wr_valid & wr_ready;
    assign push   = accept & hit;
    assign drop   = accept & ~hit;
    assign pop    = ~empty & ~freeze;

    // Fill level next state; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer, level and drop-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            drop_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            level_q <= level_d;
            if (drop && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    // Entry storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem[wptr_q]  <= hit_idx;
            addr_mem[wptr_q] <= hit_off;
            data_mem[wptr_q] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Segment write bus
    // ------------------------------------------------------------------
    assign seg_wraddr = addr_mem[rptr_q];
    assign seg_wrdata = data_mem[rptr_q];

    // One-hot enable for the head entry's segment, only when draining.
    always_comb begin
        seg_wren = '0;
        if (pop) begin
            seg_wren[idx_mem[rptr_q]] = 1'b1;
        end
    end

    assign drop_cnt   = drop_q;
    assign fifo_level = level_q;
    assign idle       = empty;

endmodule

// File: tb/tb_vram_wr_router.sv
// Directed testbench for vram_wr_router.
module tb_vram_wr_router;

    logic         clk;
    logic         rst_n;
    logic         wr_valid;
    logic         wr_ready;
    logic [11:0]  wr_addr;
    logic [127:0] wr_data;
    logic         freeze;
    logic [11:0]  seg_wraddr;
    logic [127:0] seg_wrdata;
    logic [3:0]   seg_wren;
    logic [15:0]  drop_cnt;
    logic [2:0]   fifo_level;
    logic         idle;

    int vectors = 0;
    int errors  = 0;

    vram_wr_router dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .freeze     (freeze),
        .seg_wraddr (seg_wraddr),
        .seg_wrdata (seg_wrdata),
        .seg_wren   (seg_wren),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mkd(input int i);
        return {4{32'hC0DE_0000 | 32'(i)}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] a, input logic [127:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; freeze = 1'b0;
        tick();
        tick();
        vectors++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", wr_ready); end
        vectors++; if (seg_wren !== 4'b0000) begin errors++; $display("FAIL rst_wren: got %b expected 0000", seg_wren); end
        vectors++; if (drop_cnt !== 16'h0000) begin errors++; $display("FAIL rst_drop: got %h expected 0000", drop_cnt); end
        vectors++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b expected 1", idle); end
        rst_n = 1'b1;
        #1;
        vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", wr_ready); end
    endtask

    task automatic test_single_write();
        send(12'h405, mkd(1));
        vectors++; if (seg_wren !== 4'b0010) begin errors++; $display("FAIL t1_wren: got %b expected 0010", seg_wren); end
        vectors++; if (seg_wraddr !== 12'h005) begin errors++; $display("FAIL t1_addr: got %h expected 005", seg_wraddr); end
        vectors++; if (seg_wrdata !== mkd(1)) begin errors++; $display("FAIL t1_data: got %h expected %h", seg_wrdata, mkd(1)); end
        vectors++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL t1_level: got %0d expected 1", fifo_level); end
        tick();
        vectors++; if (seg_wren !== 4'b0000) begin errors++; $display("FAIL t1_wren_off: got %b expected 0000", seg_wren); end
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL t1_idle: got %b expected 1", idle); end
    endtask

    task automatic test_boundaries();
        logic [11:0] addrs [5] = '{12'h3FF, 12'hBFF, 12'hC00, 12'hD1F, 12'hD20};
        logic [3:0]  wrens [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        logic [11:0] locs  [5] = '{12'h3FF, 12'h7FF, 12'h000, 12'h01F, 12'h000};
        int seg_writes = 0;
        for (int i = 0; i < 5; i++) begin
            send(addrs[i], mkd(16 + i));
            if (seg_wren !== 4'b0000) seg_writes++;
            vectors++; if (seg_wren !== wrens[i]) begin errors++; $display("FAIL t2_wren[%0d]: got %b expected %b", i, seg_wren, wrens[i]); end
            if (wrens[i] != 4'b0000) begin
                vectors++; if (seg_wraddr !== locs[i]) begin errors++; $display("FAIL t2_addr[%0d]: got %h expected %h", i, seg_wraddr, locs[i]); end
                vectors++; if (seg_wrdata !== mkd(16 + i)) begin errors++; $display("FAIL t2_data[%0d]: got %h expected %h", i, seg_wrdata, mkd(16 + i)); end
            end
        end
        vectors++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL t2_drop: got %0d expected 1", drop_cnt); end
        vectors++; if (seg_writes != 4) begin errors++; $display("FAIL t2_count: got %0d expected 4", seg_writes); end
        vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL t2_ready: got %b expected 1", wr_ready); end
    endtask

    task automatic test_freeze();
        logic rdy;
        int   p;
        freeze = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 12'h010 + 12'(i);
            wr_data  = mkd(32 + i);
            #1;
            vectors++; if (wr_ready !== (i < 4)) begin errors++; $display("FAIL t3_ready[%0d]: got %b expected %b", i, wr_ready, (i < 4)); end
            vectors++; if (seg_wren !== 4'b0000) begin errors++; $display("FAIL t3_frozen_wren[%0d]: got %b expected 0000", i, seg_wren); end
            tick();
        end
        vectors++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL t3_level: got %0d expected 4", fifo_level); end
        // Writes 4 and 5 are still pending; release freeze and keep offering them.
        p = 4;
        freeze = 1'b0;
        for (int j = 0; j < 6; j++) begin
            wr_valid = (p < 6);
            wr_addr  = 12'h010 + 12'(p);
            wr_data  = mkd(32 + p);
            #1;
            rdy = wr_ready;
            vectors++; if (seg_wren !== 4'b0001) begin errors++; $display("FAIL t3_wren[%0d]: got %b expected 0001", j, seg_wren); end
            vectors++; if (seg_wraddr !== 12'h010 + 12'(j)) begin errors++; $display("FAIL t3_addr[%0d]: got %h expected %h", j, seg_wraddr, 12'h010 + 12'(j)); end
            vectors++; if (seg_wrdata !== mkd(32 + j)) begin errors++; $display("FAIL t3_data[%0d]: got %h expected %h", j, seg_wrdata, mkd(32 + j)); end
            tick();
            if (rdy && wr_valid) p++;
        end
        wr_valid = 1'b0;
        vectors++; if (p != 6) begin errors++; $display("FAIL t3_accepted: got %0d expected 6", p); end
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL t3_idle: got %b expected 1", idle); end
        vectors++; if (seg_wren !== 4'b0000) begin errors++; $display("FAIL t3_wren_end: got %b expected 0000", seg_wren); end
    endtask

    task automatic test_streaming();
        freeze = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 12'h400 + 12'(i * 3);
            wr_data  = mkd(64 + i);
            #1;
            vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL t4_ready[%0d]: got %b expected 1", i, wr_ready); end
            tick();
            vectors++; if (seg_wren !== 4'b0010) begin errors++; $display("FAIL t4_wren[%0d]: got %b expected 0010", i, seg_wren); end
            vectors++; if (seg_wraddr !== 12'(i * 3)) begin errors++; $display("FAIL t4_addr[%0d]: got %h expected %h", i, seg_wraddr, 12'(i * 3)); end
            vectors++; if (seg_wrdata !== mkd(64 + i)) begin errors++; $display("FAIL t4_data[%0d]: got %h expected %h", i, seg_wrdata, mkd(64 + i)); end
            vectors++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL t4_level[%0d]: got %0d expected 1", i, fifo_level); end
        end
        wr_valid = 1'b0;
        tick();
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL t4_idle: got %b expected 1", idle); end
    endtask

    task automatic test_reset_mid();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) send(12'h100 + 12'(i), mkd(96 + i));
        vectors++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL t5_level_pre: got %0d expected 3", fifo_level); end
        rst_n = 1'b0;
        #1;
        vectors++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL t5_ready_rst: got %b expected 0", wr_ready); end
        tick();
        rst_n  = 1'b1;
        freeze = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (seg_wren !== 4'b0000) begin errors++; $display("FAIL t5_wren[%0d]: got %b expected 0000", i, seg_wren); end
            tick();
        end
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL t5_idle: got %b expected 1", idle); end
        vectors++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL t5_level: got %0d expected 0", fifo_level); end
        vectors++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL t5_drop: got %0d expected 0", drop_cnt); end
        vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL t5_ready: got %b expected 1", wr_ready); end
    endtask

    task automatic test_drop_saturation();
        freeze   = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 12'hE00;
        wr_data  = mkd(200);
        repeat (65534) tick();
        vectors++; if (drop_cnt !== 16'hFFFE) begin errors++; $display("FAIL t6_drop_fffe: got %h expected fffe", drop_cnt); end
        tick();
        vectors++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL t6_drop_ffff: got %h expected ffff", drop_cnt); end
        repeat (2) tick();
        vectors++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL t6_drop_sat: got %h expected ffff", drop_cnt); end
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL t6_idle: got %b expected 1", idle); end
        vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL t6_ready: got %b expected 1", wr_ready); end
        wr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_boundaries();
        test_freeze();
        test_streaming();
        test_reset_mid();
        test_drop_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
